// File: rtl/sipo_deser_pkg.sv
// Shared definitions for the SIPO deserializer.
//   state_e   : framing state (HUNT waits for the first sof, SHIFT assembles words)
//   cnt_width : bit-counter width for a given word width
package sipo_deser_pkg;

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Bits needed to count 0..width-1. Never less than 1.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_deser_bitcnt.sv
// Modulo-WIDTH bit position counter for the deserializer.
//   clk, rst_n : clock, asynchronous active-low reset
//   adv        : advance by one (wraps WIDTH-1 -> 0)
//   load1      : force the count to 1 (the current bit is a word MSB); beats adv
//   cnt        : current bit position within the word
//   wrap       : cnt is at WIDTH-1, i.e. the next accepted bit completes a word
module sipo_bitcnt
    import sipo_deser_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             load1,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign wrap = (cnt_q == CNT_W'(WIDTH - 1));
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load1) begin
            cnt_d = CNT_W'(1);
        end else if (adv) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer (receive end of the PISO link).
// Shifts in one bit per si_en cycle, MSB first, and presents each WIDTH-bit
// word in a holding register with a valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   si, si_en  : serial bit and its qualifier
//   sof        : with si_en, marks si as the MSB of a new word (realign)
//   po         : assembled word (holding register)
//   po_valid   : po holds an unconsumed word
//   po_ready   : consumer takes po when po_valid && po_ready
//   overrun    : sticky, a completed word was dropped; clr_ovr clears it
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter bit ALIGN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             si,
    input  logic             si_en,
    input  logic             sof,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             overrun,
    input  logic             clr_ovr
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e           state_q,    state_d;
    logic [WIDTH-1:0] shreg_q,    shreg_d;
    logic [WIDTH-1:0] po_q,       po_d;
    logic             po_valid_q, po_valid_d;
    logic             overrun_q,  overrun_d;

    logic [CNT_W-1:0] bit_cnt;
    logic             bit_wrap;
    logic             shift_en;
    logic             realign;
    logic             complete;
    logic [WIDTH-1:0] word;

    // In HUNT only an sof-tagged bit is taken; in SHIFT every enabled bit is.
    assign shift_en = si_en && ((state_q == SHIFT) || sof);
    assign realign  = si_en && sof;
    // An sof bit restarts the count at 1, so it can never complete a word.
    assign complete = shift_en && !realign && bit_wrap;
    assign word     = {shreg_q[WIDTH-2:0], si};

    sipo_bitcnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bitcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (shift_en),
        .load1 (realign),
        .cnt   (bit_cnt),
        .wrap  (bit_wrap)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        po_d       = po_q;
        po_valid_d = po_valid_q;
        overrun_d  = overrun_q;

        if (realign) begin
            state_d = SHIFT;
        end

        if (shift_en) begin
            shreg_d = word;
        end

        // Holding register: a completing word is loaded if the slot is free
        // or being emptied this same edge; otherwise it is dropped.
        if (complete) begin
            if (!po_valid_q || po_ready) begin
                po_d       = word;
                po_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (po_valid_q && po_ready) begin
            po_valid_d = 1'b0;
        end

        // Setting the flag wins over a clear in the same cycle.
        if (clr_ovr && !(complete && po_valid_q && !po_ready)) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ALIGN ? HUNT : SHIFT;
            shreg_q    <= '0;
            po_q       <= '0;
            po_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            po_q       <= po_d;
            po_valid_q <= po_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign po       = po_q;
    assign po_valid = po_valid_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_sipo_deser.sv
`timescale 1ns/100ps
module tb_sipo_deser;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             si = 1'b0;
    logic             si_en = 1'b0;
    logic             sof = 1'b0;
    logic [WIDTH-1:0] po;
    logic             po_valid;
    logic             po_ready = 1'b0;
    logic             overrun;
    logic             clr_ovr = 1'b0;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    int cyc   = 0;
    int last_pop_cyc = 0;
    int pop_gap_bad  = 0;

    logic [WIDTH-1:0] exp_q[$];

    sipo_deser #(.WIDTH(WIDTH), .ALIGN(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .si       (si),
        .si_en    (si_en),
        .sof      (sof),
        .po       (po),
        .po_valid (po_valid),
        .po_ready (po_ready),
        .overrun  (overrun),
        .clr_ovr  (clr_ovr)
    );

    always #1 clk = ~clk;

    // One clock. Inputs are already applied; if a word is being handed over
    // at the coming edge it is compared against the scoreboard first.
    // Outputs are then observed 1 ns after the rising edge.
    task automatic step();
        logic [WIDTH-1:0] exp_w;
        if (po_valid && po_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got po=%h, required no word", po);
            end else begin
                exp_w = exp_q.pop_front();
                if (po !== exp_w) begin
                    bad++;
                    $display("FAIL sb_word: got po=%h, required %h", po, exp_w);
                end else begin
                    $display("word accepted po=%h cycle=%0d", po, cyc);
                end
            end
            if (pops > 0 && (cyc - last_pop_cyc) != WIDTH) pop_gap_bad++;
            last_pop_cyc = cyc;
            pops++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_bit(input logic b, input logic s);
        si    = b;
        sof   = s;
        si_en = 1'b1;
        step();
        si_en = 1'b0;
        sof   = 1'b0;
    endtask

    // Idle cycles with garbage on si/sof, which must be ignored.
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            si    = 1'($urandom);
            sof   = 1'($urandom);
            si_en = 1'b0;
            step();
        end
        sof = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input logic first_sof);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            send_bit(w[i], (i == WIDTH - 1) ? first_sof : 1'b0);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        si_en    = 1'b0;
        sof      = 1'b0;
        clr_ovr  = 1'b0;
        po_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        exp_q.delete();
        pops = 0;
    endtask

    task automatic check_sb_empty(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_sb_left: got %0d words pending, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({po, po_valid, overrun} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got po=%h valid=%b ovr=%b, required 0/0/0", po, po_valid, overrun);
        end
        $display("reset checked po=%h valid=%b ovr=%b", po, po_valid, overrun);
    endtask

    // Scenario 1: sof-aligned D, held (po_ready=0).
    task automatic test_basic();
        do_reset();
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        total++;
        if (po_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_early_valid: got %b, required 0", po_valid);
        end
        exp_q.push_back(4'hD);
        send_bit(1'b1, 1'b0);
        total++;
        if (po_valid !== 1'b1 || po !== 4'hD) begin
            bad++;
            $display("FAIL basic_word: got valid=%b po=%h, required 1/d", po_valid, po);
        end
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL basic_ovr: got %b, required 0", overrun);
        end
        $display("basic word po=%h valid=%b", po, po_valid);
    endtask

    // Scenario 3: continues with D held; next word is dropped.
    task automatic test_overrun();
        send_word(4'hC, 1'b0);
        total++;
        if (po !== 4'hD || po_valid !== 1'b1 || overrun !== 1'b1) begin
            bad++;
            $display("FAIL ovr_drop: got po=%h valid=%b ovr=%b, required d/1/1", po, po_valid, overrun);
        end
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL ovr_clear: got %b, required 0", overrun);
        end
        po_ready = 1'b1;
        step();
        po_ready = 1'b0;
        total++;
        if (po_valid !== 1'b0 || po !== 4'hD) begin
            bad++;
            $display("FAIL ovr_accept: got valid=%b po=%h, required 0/d", po_valid, po);
        end
        check_sb_empty("ovr");
        $display("overrun scenario done ovr=%b", overrun);
    endtask

    // Scenario 2: bits before the first sof are discarded.
    task automatic test_align();
        do_reset();
        po_ready = 1'b1;
        send_word(4'hB, 1'b0);
        step();
        total++;
        if (po_valid !== 1'b0 || pops != 0) begin
            bad++;
            $display("FAIL align_hunt: got valid=%b pops=%0d, required 0/0", po_valid, pops);
        end
        exp_q.push_back(4'hB);
        send_word(4'hB, 1'b1);
        step();
        step();
        total++;
        if (pops != 1) begin
            bad++;
            $display("FAIL align_count: got %0d words, required 1", pops);
        end
        check_sb_empty("align");
    endtask

    // Scenario 4: sustained back-to-back words with po_ready held high.
    task automatic test_back_to_back();
        logic [WIDTH-1:0] words [4];
        words[0] = 4'hD; words[1] = 4'hB; words[2] = 4'hC; words[3] = 4'hD;
        do_reset();
        po_ready    = 1'b1;
        pop_gap_bad = 0;
        for (int w = 0; w < 4; w++) begin
            exp_q.push_back(words[w]);
            send_word(words[w], (w == 0));
        end
        step();
        step();
        total++;
        if (pops != 4) begin
            bad++;
            $display("FAIL b2b_count: got %0d words, required 4", pops);
        end
        total++;
        if (pop_gap_bad != 0) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d irregular gaps, required 0", pop_gap_bad);
        end
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ovr: got %b, required 0", overrun);
        end
        check_sb_empty("b2b");
    endtask

    // Scenario 5: si_en gaps, mid-word realign, async mid-word reset.
    task automatic test_gaps_realign_reset();
        do_reset();
        po_ready = 1'b1;
        exp_q.push_back(4'hD);
        send_bit(1'b1, 1'b1); gap(3);
        send_bit(1'b1, 1'b0); gap(3);
        send_bit(1'b0, 1'b0); gap(3);
        send_bit(1'b1, 1'b0); gap(3);
        // Two stray bits, then a realigning sof.
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        exp_q.push_back(4'hA);
        send_word(4'hA, 1'b1);
        step();
        step();
        total++;
        if (pops != 2) begin
            bad++;
            $display("FAIL gap_count: got %0d words, required 2", pops);
        end
        check_sb_empty("gap");
        // Fill the holder, force an overrun, leave a partial word, then reset.
        po_ready = 1'b0;
        send_word(4'h5, 1'b0);
        send_word(4'h6, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        total++;
        if (po !== 4'h5 || po_valid !== 1'b1 || overrun !== 1'b1) begin
            bad++;
            $display("FAIL prereset_state: got po=%h valid=%b ovr=%b, required 5/1/1", po, po_valid, overrun);
        end
        #0.5 rst_n = 1'b0;
        #0.2;
        total++;
        if ({po, po_valid, overrun} !== '0) begin
            bad++;
            $display("FAIL async_reset: got po=%h valid=%b ovr=%b, required 0/0/0", po, po_valid, overrun);
        end
        $display("async reset po=%h valid=%b ovr=%b", po, po_valid, overrun);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        // Back in HUNT: unaligned bits are ignored, an sof word is taken.
        po_ready = 1'b1;
        pops = 0;
        send_word(4'hF, 1'b0);
        step();
        total++;
        if (po_valid !== 1'b0 || pops != 0) begin
            bad++;
            $display("FAIL reset_hunt: got valid=%b pops=%0d, required 0/0", po_valid, pops);
        end
        exp_q.push_back(4'h9);
        send_word(4'h9, 1'b1);
        step();
        step();
        check_sb_empty("rehunt");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_align();
        test_back_to_back();
        test_gaps_realign_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
